mem_access_unit: RTL



---
 rtl/mem_access_unit_if.sv | 26 ++
 rtl/mem_access_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response bus between the pipeline MEM stage (master) and the
// memory access unit (slave).
interface mem_access_unit_if #(
  parameter int unsigned ADDR_BITS = 12
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [1:0]           req_size;
  logic                 req_signed;
  logic [ADDR_BITS-1:0] req_addr;
  logic [31:0]          req_wdata;
  logic                 resp_valid;
  logic [31:0]          resp_rdata;
  logic                 resp_error;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/mem_access_unit.sv
// Converts byte-addressed MEM-stage loads/stores into word-addressed data-RAM
// transactions, sequencing the RAM's one-cycle registered read latency.
module mem_access_unit #(
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_access_unit_if.slave      bus,
  output logic                  ram_rw,
  output logic                  ram_extend_type,
  output logic [3:0]            ram_sel,
  output logic [ADDR_BITS-3:0]  ram_addr,
  output logic [31:0]           ram_data_in,
  input  logic [31:0]           ram_data_out
);

  localparam int unsigned WORD_ADDR_BITS = ADDR_BITS - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state;
  logic   write_q;

  logic        err_c;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c;
  logic        accept_c;

  assign accept_c = bus.req_valid && bus.req_ready;

  // Decode alignment error, lane mask and lane-replicated store data.
  always_comb begin
    err_c   = 1'b0;
    sel_c   = 4'b0000;
    wdata_c = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        sel_c   = 4'b0001 << bus.req_addr[1:0];
        wdata_c = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        err_c   = bus.req_addr[0];
        sel_c   = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        err_c = (bus.req_addr[1:0] != 2'b00);
        sel_c = 4'b1111;
      end
      default: begin
        err_c = 1'b1;
      end
    endcase
  end

  // RAM strobes are only non-zero for the single ISSUE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      write_q         <= 1'b0;
      bus.req_ready   <= 1'b0;
      bus.resp_valid  <= 1'b0;
      bus.resp_rdata  <= 32'd0;
      bus.resp_error  <= 1'b0;
      ram_rw          <= 1'b0;
      ram_extend_type <= 1'b0;
      ram_sel         <= 4'b0000;
      ram_addr        <= WORD_ADDR_BITS'(0);
      ram_data_in     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            bus.req_ready <= 1'b0;
            write_q       <= bus.req_write;
            bus.resp_rdata <= 32'd0;
            if (err_c) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_error <= 1'b1;
            end else begin
              state           <= ISSUE;
              bus.resp_error  <= 1'b0;
              ram_sel         <= sel_c;
              ram_addr        <= bus.req_addr[ADDR_BITS-1:2];
              ram_rw          <= bus.req_write;
              ram_data_in     <= bus.req_write ? wdata_c : 32'd0;
              ram_extend_type <= !bus.req_write && bus.req_signed;
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        ISSUE: begin
          ram_sel         <= 4'b0000;
          ram_rw          <= 1'b0;
          ram_extend_type <= 1'b0;
          ram_data_in     <= 32'd0;
          if (write_q) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
          end else begin
            state <= READ;
          end
        end
        READ: begin
          // RAM output is only valid during this cycle; sel=0 zeroes it after.
          bus.resp_rdata <= ram_data_out;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
          state          <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
